// File: rtl/fifo_rd_arbiter_if.sv
// Bus bundle for fifo_rd_arbiter: requester side, FIFO read port and the
// delivered-word stream.  The arbiter uses the master modport and the
// surrounding logic (or testbench) uses the slave modport.
//
// Handshake rules: r_en is a one-way strobe to the FIFO, and r_data is valid
// exactly one cycle after an r_en cycle.  The output stream is valid/ready.
// out_valid, once raised, stays high with out_data unchanged until the cycle
// where out_ready is also high.  That cycle is the transfer.  out_valid never
// depends on out_ready.
interface fifo_rd_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int N_REQ      = 4,
   parameter int LEN_W      = 4
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*LEN_W-1:0] req_len;
   logic                   empty;
   logic                   r_en;
   logic [DATA_WIDTH-1:0]  r_data;
   logic [N_REQ-1:0]       gnt;
   logic                   out_valid;
   logic [DATA_WIDTH-1:0]  out_data;
   logic                   out_ready;
   logic                   done;
   logic [1:0]             dbg_state;

   modport master (
      input  req, req_len, empty, r_data, out_ready,
      output r_en, gnt, out_valid, out_data, done, dbg_state
   );

   modport slave (
      output req, req_len, empty, r_data, out_ready,
      input  r_en, gnt, out_valid, out_data, done, dbg_state
   );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter in front of a FIFO read port.  One requester at a
// time owns the FIFO for a burst of L+1 words.  Words pass through a 2-entry
// output buffer, so the FIFO read latency never drops data when out_ready
// stalls.  The FSM state is exported on dbg_state as follows:
// 0 = idle, 1 = burst, 2 = done.
module fifo_rd_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int N_REQ      = 4,
   parameter int LEN_W      = 4
) (
   input  logic clk_r,
   input  logic arst_n,
   fifo_rd_arbiter_if.master bus
);

   localparam int PTR_W = $clog2(N_REQ);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BURST = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]            state;
   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      gnt_idx;
   logic [N_REQ-1:0]      gnt_q;
   logic [LEN_W-1:0]      len_q;
   logic [LEN_W:0]        issued;
   logic [LEN_W:0]        delivered;
   logic [LEN_W:0]        burst_words;

   logic                  sel_found;
   logic [PTR_W-1:0]      sel_idx;
   logic [LEN_W-1:0]      sel_len;

   logic                  inflight;
   logic [DATA_WIDTH-1:0] buf0;
   logic [DATA_WIDTH-1:0] buf1;
   logic                  buf_rd;
   logic                  buf_wr;
   logic [1:0]            held;
   logic [1:0]            occ;
   logic                  out_valid_c;
   logic                  xfer;
   logic                  r_en_c;

   // Round-robin pick: the first requester at or after ptr, wrapping modulo N_REQ.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!sel_found && bus.req[(int'(ptr) + i) % N_REQ]) begin
            sel_found = 1'b1;
            sel_idx   = PTR_W'((int'(ptr) + i) % N_REQ);
         end
      end
   end

   assign sel_len     = bus.req_len[int'(sel_idx)*LEN_W +: LEN_W];
   assign burst_words = {1'b0, len_q} + {{LEN_W{1'b0}}, 1'b1};

   assign out_valid_c = (held != 2'd0);
   assign xfer        = out_valid_c & bus.out_ready;

   // This is the buffer occupancy at the end of the cycle.  A word leaving this
   // cycle frees its slot, and the word already in flight claims one.  Issuing
   // only while occ < 2 means the buffer never exceeds 2 entries.  Counting the
   // outgoing word also allows one word per cycle at full throughput.
   assign occ = held - {1'b0, xfer} + {1'b0, inflight};

   assign r_en_c = (state == S_BURST) & ~bus.empty & (issued < burst_words) & (occ < 2'd2);

   // Control FSM: grant, count issued and delivered words, pulse done, then advance ptr.
   always_ff @(posedge clk_r or negedge arst_n) begin
      if (!arst_n) begin
         state     <= S_IDLE;
         ptr       <= '0;
         gnt_idx   <= '0;
         gnt_q     <= '0;
         len_q     <= '0;
         issued    <= '0;
         delivered <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_found) begin
                  state     <= S_BURST;
                  gnt_idx   <= sel_idx;
                  gnt_q     <= N_REQ'(1) << sel_idx;
                  len_q     <= sel_len;
                  issued    <= '0;
                  delivered <= '0;
               end
            end
            S_BURST: begin
               if (r_en_c) begin
                  issued <= issued + {{LEN_W{1'b0}}, 1'b1};
               end
               if (xfer) begin
                  delivered <= delivered + {{LEN_W{1'b0}}, 1'b1};
                  if (delivered == {1'b0, len_q}) begin
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               gnt_q <= '0;
               if (gnt_idx == PTR_W'(N_REQ - 1)) begin
                  ptr <= '0;
               end else begin
                  ptr <= gnt_idx + PTR_W'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               gnt_q <= '0;
            end
         endcase
      end
   end

   // Output buffer: capture r_data one cycle after r_en and pop it on transfer, in FIFO order.
   always_ff @(posedge clk_r or negedge arst_n) begin
      if (!arst_n) begin
         inflight <= 1'b0;
         buf0     <= '0;
         buf1     <= '0;
         buf_rd   <= 1'b0;
         buf_wr   <= 1'b0;
         held     <= 2'd0;
      end else begin
         inflight <= r_en_c;
         if (inflight) begin
            if (buf_wr) begin
               buf1 <= bus.r_data;
            end else begin
               buf0 <= bus.r_data;
            end
            buf_wr <= ~buf_wr;
         end
         if (xfer) begin
            buf_rd <= ~buf_rd;
         end
         held <= occ;
      end
   end

   assign bus.r_en      = r_en_c;
   assign bus.gnt       = gnt_q;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = buf_rd ? buf1 : buf0;
   assign bus.done      = (state == S_DONE);
   assign bus.dbg_state = state;

endmodule
